// File: rtl/spw_pkg.sv
// rtl/spw_pkg.sv - shared credit constants and FCT FSM state type
package spw_pkg;

  localparam logic [6:0] CREDIT_MAX = 7'd56;
  localparam logic [6:0] FCT_CREDIT = 7'd8;

  typedef enum logic {
    FCT_IDLE    = 1'b0,
    FCT_REQUEST = 1'b1
  } fct_state_e;

endpackage

// File: rtl/spw_credit_counter.sv
// rtl/spw_credit_counter.sv - saturating 6-bit credit counter, +8 / -1 with overflow/underflow flags
module spw_credit_counter
  import spw_pkg::*;
(
  input  logic       CLOCK,
  input  logic       RESETn,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [5:0] count_o,
  output logic       overflow_o,
  output logic       underflow_o
);

  logic [5:0] count_q, count_d;
  logic [6:0] sum;

  // A rejected update leaves the count untouched; the flags tell the owner why.
  always_comb begin
    sum         = {1'b0, count_q} + (inc_i ? FCT_CREDIT : 7'd0) - {6'd0, dec_i};
    overflow_o  = inc_i && (sum > CREDIT_MAX);
    underflow_o = dec_i && !inc_i && (count_q == 6'd0);
    count_d     = count_q;
    if (clr_i) begin
      count_d = 6'd0;
    end else if (!overflow_o && !underflow_o) begin
      count_d = sum[5:0];
    end
  end

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      count_q <= 6'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/spw_credit_ctrl.sv
// rtl/spw_credit_ctrl.sv - SpaceWire TX/RX flow-control credit tracking and FCT request FSM
module spw_credit_ctrl
  import spw_pkg::*;
(
  input  logic       CLOCK,
  input  logic       RESETn,
  input  logic       enableTx,
  input  logic       enableRx,
  input  logic       sendFCTs,
  input  logic       gotFCT,
  input  logic       gotNChar,
  input  logic       txNCharSent,
  input  logic       fctSent,
  input  logic [6:0] rxFifoFree,
  output logic       fctRequest,
  output logic [5:0] txCredit,
  output logic       txCreditAvail,
  output logic [5:0] rxCredit,
  output logic       creditError
);

  fct_state_e state_q, state_d;
  logic       err_q, err_d;
  logic       rx_inc;
  logic       tx_ovf, tx_unf_unused, rx_ovf, rx_unf;
  logic [6:0] rx_next_grant;

  // Only an FCT that was actually requested, and is still permitted, earns credit.
  assign rx_inc        = (state_q == FCT_REQUEST) && fctSent && sendFCTs && enableRx;
  assign rx_next_grant = {1'b0, rxCredit} + FCT_CREDIT;

  spw_credit_counter u_tx_cnt (
    .CLOCK       (CLOCK),
    .RESETn      (RESETn),
    .clr_i       (!enableTx),
    .inc_i       (gotFCT),
    .dec_i       (txNCharSent),
    .count_o     (txCredit),
    .overflow_o  (tx_ovf),
    .underflow_o (tx_unf_unused)
  );

  spw_credit_counter u_rx_cnt (
    .CLOCK       (CLOCK),
    .RESETn      (RESETn),
    .clr_i       (!enableRx),
    .inc_i       (rx_inc),
    .dec_i       (gotNChar),
    .count_o     (rxCredit),
    .overflow_o  (rx_ovf),
    .underflow_o (rx_unf)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      FCT_IDLE: begin
        if (sendFCTs && enableRx && !err_q &&
            (rx_next_grant <= CREDIT_MAX) && (rxFifoFree >= rx_next_grant)) begin
          state_d = FCT_REQUEST;
        end
      end
      FCT_REQUEST: begin
        if (fctSent || !sendFCTs || !enableRx) begin
          state_d = FCT_IDLE;
        end
      end
      default: state_d = FCT_IDLE;
    endcase
    if (!enableRx) begin
      state_d = FCT_IDLE;
    end
  end

  // Disabling either direction clears the error, even against a same-cycle violation.
  always_comb begin
    err_d = err_q;
    if (!enableRx || !enableTx) begin
      err_d = 1'b0;
    end else if (tx_ovf || rx_ovf || rx_unf) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= FCT_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign fctRequest    = (state_q == FCT_REQUEST);
  assign txCreditAvail = (txCredit != 6'd0);
  assign creditError   = err_q;

endmodule

// File: tb/tb_spw_credit_ctrl.sv
// tb/tb_spw_credit_ctrl.sv - self-checking bench for spw_credit_ctrl
module tb_spw_credit_ctrl;

  logic       CLOCK = 1'b0;
  logic       RESETn;
  logic       enableTx, enableRx, sendFCTs;
  logic       gotFCT, gotNChar, txNCharSent, fctSent;
  logic [6:0] rxFifoFree;
  logic       fctRequest, txCreditAvail, creditError;
  logic [5:0] txCredit, rxCredit;

  int checks = 0;
  int errors = 0;

  int m_tx, m_rx;
  bit m_err, m_req;

  spw_credit_ctrl dut (
    .CLOCK         (CLOCK),
    .RESETn        (RESETn),
    .enableTx      (enableTx),
    .enableRx      (enableRx),
    .sendFCTs      (sendFCTs),
    .gotFCT        (gotFCT),
    .gotNChar      (gotNChar),
    .txNCharSent   (txNCharSent),
    .fctSent       (fctSent),
    .rxFifoFree    (rxFifoFree),
    .fctRequest    (fctRequest),
    .txCredit      (txCredit),
    .txCreditAvail (txCreditAvail),
    .rxCredit      (rxCredit),
    .creditError   (creditError)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Credit bookkeeping straight from the link rules, in integers.
  task automatic model_edge();
    int  ntx, nrx;
    bit  nreq, tx_bad, rx_bad, credited;
    tx_bad = 1'b0;
    ntx = m_tx + (gotFCT ? 8 : 0) - (txNCharSent ? 1 : 0);
    if (gotFCT && ntx > 56) begin
      ntx = m_tx;
      tx_bad = 1'b1;
    end
    if (ntx < 0) ntx = 0;
    if (!enableTx) ntx = 0;

    credited = m_req && fctSent && sendFCTs && enableRx;
    nrx = m_rx + (credited ? 8 : 0) - (gotNChar ? 1 : 0);
    rx_bad = gotNChar && (m_rx == 0) && !credited;
    if (rx_bad) nrx = 0;
    if (!enableRx) nrx = 0;

    if (!enableRx) nreq = 1'b0;
    else if (m_req) nreq = !(fctSent || !sendFCTs);
    else nreq = sendFCTs && !m_err && (m_rx + 8 <= 56) && (int'(rxFifoFree) >= m_rx + 8);

    if (!enableRx || !enableTx) m_err = 1'b0;
    else m_err = m_err || tx_bad || rx_bad;
    m_tx  = ntx;
    m_rx  = nrx;
    m_req = nreq;
  endtask

  task automatic check_all();
    chk("txCredit", {1'b0, txCredit}, 7'(m_tx));
    chk("txCreditAvail", {6'd0, txCreditAvail}, {6'd0, m_tx != 0});
    chk("rxCredit", {1'b0, rxCredit}, 7'(m_rx));
    chk("fctRequest", {6'd0, fctRequest}, {6'd0, m_req});
    chk("creditError", {6'd0, creditError}, {6'd0, m_err});
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
    model_edge();
    check_all();
    gotFCT = 1'b0; gotNChar = 1'b0; txNCharSent = 1'b0; fctSent = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx"}, {1'b0, txCredit}, 7'd0);
    chk({tag, "_txav"}, {6'd0, txCreditAvail}, 7'd0);
    chk({tag, "_rx"}, {1'b0, rxCredit}, 7'd0);
    chk({tag, "_req"}, {6'd0, fctRequest}, 7'd0);
    chk({tag, "_err"}, {6'd0, creditError}, 7'd0);
  endtask

  initial begin
    RESETn = 1'b0;
    enableTx = 1'b0; enableRx = 1'b0; sendFCTs = 1'b0;
    gotFCT = 1'b0; gotNChar = 1'b0; txNCharSent = 1'b0; fctSent = 1'b0;
    rxFifoFree = 7'd0;
    m_tx = 0; m_rx = 0; m_err = 1'b0; m_req = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RESETn = 1'b1;
    enableTx = 1'b1; enableRx = 1'b1;
    tick();

    // Seven FCTs fill TX credit; the eighth is a violation.
    for (int i = 0; i < 7; i++) begin gotFCT = 1'b1; tick(); end
    chk("fill_tx56", {1'b0, txCredit}, 7'd56);
    chk("fill_noerr", {6'd0, creditError}, 7'd0);
    gotFCT = 1'b1; tick();
    chk("ovf_err", {6'd0, creditError}, 7'd1);
    chk("ovf_hold", {1'b0, txCredit}, 7'd56);

    enableTx = 1'b0; tick();
    chk("txdis_clear", {1'b0, txCredit}, 7'd0);
    enableTx = 1'b1;
    gotFCT = 1'b1; tick();
    gotFCT = 1'b1; txNCharSent = 1'b1; tick();
    chk("fct_and_nchar", {1'b0, txCredit}, 7'd15);
    chk("fct_and_nchar_err", {6'd0, creditError}, 7'd0);
    for (int i = 0; i < 17; i++) begin txNCharSent = 1'b1; tick(); end
    chk("tx_drain_zero", {1'b0, txCredit}, 7'd0);
    chk("tx_drain_noerr", {6'd0, creditError}, 7'd0);

    // FCT handshake with ample FIFO space, then limited space.
    sendFCTs = 1'b1; rxFifoFree = 7'd64;
    for (int i = 0; i < 80; i++) begin fctSent = fctRequest; tick(); end
    chk("rx_full56", {1'b0, rxCredit}, 7'd56);
    chk("rx_full_noreq", {6'd0, fctRequest}, 7'd0);
    enableRx = 1'b0; tick();
    enableRx = 1'b1; rxFifoFree = 7'd20;
    for (int i = 0; i < 30; i++) begin fctSent = fctRequest; tick(); end
    chk("rx_fifo20", {1'b0, rxCredit}, 7'd16);

    // N-Char with no RX credit.
    sendFCTs = 1'b0; enableRx = 1'b0; tick();
    enableRx = 1'b1; tick();
    gotNChar = 1'b1; tick();
    chk("rx_unf_err", {6'd0, creditError}, 7'd1);
    chk("rx_unf_zero", {1'b0, rxCredit}, 7'd0);
    enableRx = 1'b0; tick();
    chk("rxdis_err_clr", {6'd0, creditError}, 7'd0);
    chk("rxdis_rx_clr", {1'b0, rxCredit}, 7'd0);
    enableRx = 1'b1; tick();

    // fctSent and gotNChar together while requesting.
    sendFCTs = 1'b1; rxFifoFree = 7'd64;
    for (int i = 0; i < 10; i++) begin fctSent = fctRequest && (m_rx == 0); tick(); end
    chk("coinc_inreq", {6'd0, fctRequest}, 7'd1);
    fctSent = 1'b1; gotNChar = 1'b1; tick();
    chk("coinc_rx15", {1'b0, rxCredit}, 7'd15);
    chk("coinc_idle", {6'd0, fctRequest}, 7'd0);
    chk("coinc_noerr", {6'd0, creditError}, 7'd0);

    for (int i = 0; i < 400; i++) begin
      enableTx    = ($urandom_range(0, 31) != 0);
      enableRx    = ($urandom_range(0, 31) != 0);
      sendFCTs    = ($urandom_range(0, 3) != 0);
      gotFCT      = ($urandom_range(0, 5) == 0);
      gotNChar    = ($urandom_range(0, 4) == 0);
      txNCharSent = ($urandom_range(0, 2) == 0);
      fctSent     = fctRequest ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      rxFifoFree  = 7'($urandom_range(0, 64));
      tick();
    end

    // Asynchronous reset in the middle of a request.
    enableTx = 1'b0; enableRx = 1'b0; sendFCTs = 1'b0; tick();
    enableTx = 1'b1; enableRx = 1'b1; sendFCTs = 1'b1; rxFifoFree = 7'd64;
    for (int i = 0; i < 40 && !(fctRequest && m_rx == 24); i++) begin
      gotFCT  = (m_tx < 40);
      fctSent = fctRequest && (m_rx < 24);
      tick();
    end
    chk("arst_setup_rx", {1'b0, rxCredit}, 7'd24);
    chk("arst_setup_tx", {1'b0, txCredit}, 7'd40);
    chk("arst_setup_req", {6'd0, fctRequest}, 7'd1);
    #2;
    RESETn = 1'b0;
    #1;
    chk_all_zero("arst");
    @(negedge CLOCK);
    RESETn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spw_credit_ctrl.md
SPW_CREDIT_CTRL -- requirements
Module: spw_credit_ctrl

Interface
REQ-001 SHALL have port CLOCK input 1: global clock; all logic on its rising edge.
REQ-002 SHALL have port RESETn input 1: reset, asynchronous, active-low.
REQ-003 SHALL have port enableTx input 1: link FSM TX enable; low clears all TX credit state.
REQ-004 SHALL have port enableRx input 1: link FSM RX enable; low clears RX credit state and creditError.
REQ-005 SHALL have port sendFCTs input 1: link FSM permission to issue FCTs (CONNECTING/RUN).
REQ-006 SHALL have port gotFCT input 1: one-cycle pulse, FCT received from peer.
REQ-007 SHALL have port gotNChar input 1: one-cycle pulse, N-Char received from peer.
REQ-008 SHALL have port txNCharSent input 1: one-cycle pulse, local transmitter emitted an N-Char.
REQ-009 SHALL have port fctSent input 1: one-cycle pulse, transmitter emitted the requested FCT.
REQ-010 SHALL have port rxFifoFree input 7: free entries in receive FIFO, 0..64.
REQ-011 SHALL have port fctRequest output 1: request to transmitter to send one FCT.
REQ-012 SHALL have port txCredit output 6: N-Chars local side may still send, 0..56.
REQ-013 SHALL have port txCreditAvail output 1: high when txCredit != 0.
REQ-014 SHALL have port rxCredit output 6: N-Chars peer is still entitled to send, 0..56.
REQ-015 SHALL have port creditError output 1: registered, sticky credit violation to link FSM.

Function
REQ-016 Constants SHALL be CREDIT_MAX = 56 and FCT_CREDIT = 8.
REQ-017 TX next value SHALL be txCredit + 8·gotFCT − txNCharSent, computed in 7 bits.
- If next > 56: set creditError next cycle; txCredit holds.
- Otherwise: txCredit takes next.
REQ-018 txNCharSent with txCredit = 0 SHALL leave txCredit at 0 without error; transmitter gating on txCreditAvail is a TX responsibility.
REQ-019 FCT FSM SHALL have states IDLE and REQUEST; fctRequest = (state == REQUEST).
REQ-020 IDLE -> REQUEST SHALL occur when all hold: sendFCTs = 1, enableRx = 1, creditError = 0, rxCredit + 8 <= 56, rxFifoFree >= rxCredit + 8.
REQ-021 REQUEST -> IDLE SHALL occur on fctSent, with rxCredit += 8 in the same edge.
- REQUEST -> IDLE without credit SHALL also occur if sendFCTs or enableRx falls.
REQ-022 fctSent while in IDLE SHALL be ignored.
REQ-023 gotNChar SHALL decrement rxCredit.
- If gotNChar and fctSent coincide in REQUEST: net +7.
- If gotNChar arrives with rxCredit = 0 and no simultaneous credited fctSent: set creditError; rxCredit stays 0.
REQ-024 creditError SHALL stay high until enableRx = 0 or enableTx = 0 is sampled; the clear SHALL take priority over a same-cycle set.
REQ-025 enableTx = 0 SHALL clear txCredit to 0 on the next edge.
REQ-026 enableRx = 0 SHALL clear rxCredit to 0, return the FSM to IDLE, and clear creditError on the next edge.
REQ-027 All outputs SHALL be registered or decoded from registers only; latency from any input pulse to its effect on an output SHALL be exactly 1 cycle.
REQ-028 After REQUEST -> IDLE, at least one IDLE cycle SHALL pass before re-entering REQUEST.

Reset
REQ-029 RESETn low SHALL asynchronously force the following, independent of CLOCK:
- txCredit = 0, rxCredit = 0
- FSM = IDLE, fctRequest = 0
- txCreditAvail = 0, creditError = 0
REQ-030 After RESETn deasserts, first update SHALL occur on the next CLOCK rising edge.

Structure
REQ-031 CREDIT_MAX, FCT_CREDIT and the FCT FSM state typedef SHALL live in shared package spw_pkg.
REQ-032 A sub-module spw_credit_counter SHALL implement the shared counter behaviour and be instantiated for both TX and RX credit:
- saturating 6-bit up/down counter
- +8 / −1 inputs
- overflow/underflow flags
- synchronous clear

Verification
REQ-033 Seven gotFCT pulses with enableTx = 1 -> txCredit = 56, creditError = 0; an eighth gotFCT -> creditError = 1, txCredit = 56.
REQ-034 txCredit = 8, gotFCT and txNCharSent in the same cycle -> txCredit = 15, no error.
REQ-035 sendFCTs = 1, rxFifoFree = 64, fctSent one cycle after every fctRequest:
- requests repeat until rxCredit = 56, then fctRequest stays 0.
- With rxFifoFree = 20: rxCredit stops at 16.
REQ-036 rxCredit = 0, gotNChar pulse -> creditError = 1 next cycle; enableRx = 0 for one cycle -> creditError = 0, rxCredit = 0.
REQ-037 RESETn asserted mid-REQUEST with rxCredit = 24, txCredit = 40 -> all outputs 0 immediately, without a clock edge.
REQ-038 In REQUEST with rxCredit = 8, fctSent and gotNChar coincide -> rxCredit = 15, FSM = IDLE, no error.
